serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 99 +++++++++
 tb/tb_serial_adder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder, one full-adder slice per clock
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic             bit_s;
    logic             carry_n;
    logic             last;
    logic [WIDTH:0]   acc_ext;
    logic [WIDTH-1:0] acc_n;

    // Single full-adder slice fed by the low operand bits and the stored carry
    always_comb begin
        bit_s   = a_sh[0] ^ b_sh[0] ^ carry;
        carry_n = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        acc_ext = {bit_s, acc};
        acc_n   = acc_ext[WIDTH:1];
        last    = (cnt == CW'(WIDTH - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= c_in;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= carry_n;
                    acc   <= acc_n;
                    cnt   <= cnt + 1'b1;
                    // Result registers move only on the final slice so they hold during SHIFT
                    if (last) begin
                        sum   <= acc_n;
                        c_out <= carry_n;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder at WIDTH=8 and WIDTH=3
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start3, cin3, busy3, done3, cout3;
    logic [2:0] a3, b3, sum3;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_sum8  = '0;
    logic       exp_cout8 = 1'b0;
    logic [2:0] exp_sum3  = '0;
    logic       exp_cout3 = 1'b0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_in(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8)
    );

    serial_adder #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .c_in(cin3),
        .busy(busy3), .done(done3), .sum(sum3), .c_out(cout3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 addition; hold keeps start high, inj raises start during that SHIFT cycle
    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input bit hold, input int inj);
        logic [8:0] r;
        r = {1'b0, av} + {1'b0, bv} + {8'd0, cv};
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        tick();
        if (!hold) start8 = 1'b0;
        chk("w8_accept_busy", busy8, 1);
        chk("w8_accept_done", done8, 0);
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        for (int k = 1; k <= 8; k++) begin
            if (k == inj) begin
                start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
            end
            tick();
            if (k == inj && !hold) start8 = 1'b0;
            if (k < 8) begin
                chk("w8_shift_busy", busy8, 1);
                chk("w8_shift_done", done8, 0);
                chk("w8_shift_sum_hold", sum8, exp_sum8);
                chk("w8_shift_cout_hold", cout8, exp_cout8);
            end else begin
                exp_sum8  = r[7:0];
                exp_cout8 = r[8];
                chk("w8_done_pulse", done8, 1);
                chk("w8_done_busy", busy8, 1);
                chk("w8_sum", sum8, exp_sum8);
                chk("w8_cout", cout8, exp_cout8);
            end
        end
        tick();
        chk("w8_idle_busy", busy8, 0);
        chk("w8_idle_done", done8, 0);
        chk("w8_idle_sum", sum8, exp_sum8);
    endtask

    task automatic run3(input logic [2:0] av, input logic [2:0] bv, input logic cv);
        logic [3:0] r;
        r = {1'b0, av} + {1'b0, bv} + {3'd0, cv};
        a3 = av; b3 = bv; cin3 = cv; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        a3 = 3'($urandom); b3 = 3'($urandom); cin3 = 1'($urandom);
        chk("w3_accept_busy", busy3, 1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("w3_done_timing", done3, (k == 3) ? 1 : 0);
            chk("w3_busy", busy3, 1);
        end
        exp_sum3  = r[2:0];
        exp_cout3 = r[3];
        chk("w3_sum", sum3, exp_sum3);
        chk("w3_cout", cout3, exp_cout3);
        tick();
        chk("w3_idle_busy", busy3, 0);
        chk("w3_idle_done", done3, 0);
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
        tick(); tick();
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_sum8", sum8, 0);
        chk("rst_cout8", cout8, 0);
        chk("rst_busy3", busy3, 0);
        chk("rst_sum3", sum3, 0);
        rst = 1'b0;
        tick();

        run8(8'h5A, 8'h3C, 1'b0, 1'b0, 0);
        run8(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run8(8'hFF, 8'hFF, 1'b1, 1'b0, 0);

        // A start raised mid-operation must not be queued
        run8(8'h01, 8'h01, 1'b0, 1'b0, 3);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ignored_start_busy", busy8, 0);
            chk("ignored_start_done", done8, 0);
        end

        // Start held high: back-to-back accepts every WIDTH+2 cycles
        run8(8'h10, 8'h20, 1'b0, 1'b1, 0);
        run8(8'h10, 8'h20, 1'b0, 1'b1, 0);
        run8(8'h10, 8'h20, 1'b0, 1'b1, 0);
        start8 = 1'b0;
        tick();

        // Async reset in the middle of 0x7F+0x01
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        chk("pre_rst_busy", busy8, 1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy8, 0);
        chk("midrst_done", done8, 0);
        chk("midrst_sum", sum8, 0);
        chk("midrst_cout", cout8, 0);
        exp_sum8 = '0; exp_cout8 = 1'b0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("post_rst_no_done", done8, 0);
            chk("post_rst_busy", busy8, 0);
        end
        run8(8'h03, 8'h04, 1'b0, 1'b0, 0);

        for (int i = 0; i < 20; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 0);

        for (int i = 0; i < 128; i++) begin
            logic [6:0] v;
            v = 7'(i);
            run3(v[6:4], v[3:1], v[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
